cell_fetch: RTL
===============

# cell_fetch

Heap-cell fetch engine between the evaluator core and the memory controller's read port. Accepts a cell address over a valid/ready request channel and reads the tag word at that address. Reads the payload words the tag calls for: one for a number, two (car, cdr) for a cons. Returns tag and payload, or an error code, over a valid/ready response channel.

## Interface
Parameters:
- ADDR_WIDTH, 16, heap address width
- DATA_WIDTH, 16, heap word width
- READ_LATENCY, 2, memory read latency in cycles (legal 1..4)
- TAG_NUMBER, 16'h0001, tag word of a number cell (1 payload word)
- TAG_CONS, 16'h0002, tag word of a cons cell (2 payload words: car, cdr)
- HEAP_TOP, 16'hFFFF, highest legal heap address (used only with bounds check)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  engine can accept; high only in IDLE and rst low
- req_addr  in  ADDR_WIDTH  cell base address
- mem_re  out  1  read strobe, one cycle per word
- mem_addr  out  ADDR_WIDTH  read address, valid while mem_re high
- mem_rdata  in  DATA_WIDTH  read data
- mem_error  in  1  memory controller fault
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_tag  out  DATA_WIDTH  tag word read
- rsp_word0  out  DATA_WIDTH  number value, or car
- rsp_word1  out  DATA_WIDTH  cdr; 0 for number cells
- rsp_err  out  2  0 OK, 1 BAD_TAG, 2 MEM_FAULT, 3 BOUNDS

## Operation
- States: IDLE, TAG_RD, W0_RD, W1_RD, RESP.
- IDLE: on req_valid & req_ready, latch base = req_addr, clear rsp_* registers, go to TAG_RD.
- Each *_RD state: mem_re high in its first cycle only, with mem_addr = base, base+1, base+2 respectively. A down-counter then waits; mem_rdata is sampled in cycle t+READ_LATENCY, where t is the mem_re cycle.
- TAG_RD capture: store rsp_tag.
  - TAG_NUMBER -> W0_RD.
  - TAG_CONS -> W0_RD.
  - Any other tag -> RESP with rsp_err=1.
- W0_RD capture: store rsp_word0.
  - Number -> RESP.
  - Cons -> W1_RD.
- W1_RD capture: store rsp_word1 -> RESP.
- mem_error high in any cycle of a *_RD state aborts:
  - next state RESP, rsp_err=2;
  - no further mem_re;
  - data already captured is retained.
- mem_error has priority over tag decode in the same cycle.
- RESP: rsp_valid high; all rsp_* fields stable until the cycle where rsp_ready is high, then IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH.
- Only one request is in flight; req_ready stays low from acceptance until the response is consumed.

## Timing
- Acceptance cycle = 0; L = READ_LATENCY. First cycle of rsp_valid:
  - Number: cycle 2L+3.
  - Cons: cycle 3L+4.
  - Bad tag: cycle L+2.
- rsp_ready high in the first RESP cycle: req_ready is high in the following cycle.
- A new request accepted then issues mem_re one cycle later.
- Reset values: req_ready 0 while rst high, then 1; mem_re 0; mem_addr 0; rsp_valid 0; rsp_tag, rsp_word0, rsp_word1 0; rsp_err 0.
- rst mid-operation: next cycle is IDLE. In-flight read data returning afterwards is ignored; no response is produced.

## Configuration
- Macro CELL_FETCH_BOUNDS_CHECK_EN.
- Defined:
  - In IDLE at acceptance, base > HEAP_TOP -> RESP in cycle 1 with rsp_err=3 and no mem_re.
  - At tag decode, base+n > HEAP_TOP, computed ADDR_WIDTH+1 bits wide (n = 1 number, 2 cons), -> RESP with rsp_err=3 and no payload reads.
  - Wrap past 2^ADDR_WIDTH therefore always errors.
- Undefined: no checks; code 3 is never produced; addresses wrap silently.

## Test plan
- L=2, mem[0x10]=TAG_NUMBER, mem[0x11]=0x002A; request 0x10 -> rsp_valid in cycle 7; tag=0x0001, word0=0x002A, word1=0, err=0; exactly 2 mem_re pulses.
- L=2, mem[0x20]=TAG_CONS, [0x21]=0x0030, [0x22]=0x0040 -> rsp_valid in cycle 10; word0=0x0030, word1=0x0040, err=0; 3 mem_re pulses at addresses 0x20, 0x21, 0x22.
- mem[0x05]=0x00FF -> err=1, tag=0x00FF, rsp_valid in cycle 4, single mem_re.
- Cons fetch with mem_error pulsed during W1_RD wait -> err=2, word0 valid, no third-word capture. Hold rsp_ready low 5 cycles -> fields stable throughout.
- With CELL_FETCH_BOUNDS_CHECK_EN, HEAP_TOP=0x00FF: request 0x0100 -> err=3 in cycle 1, no mem_re. Cons at 0x00FE -> err=3 after tag read, 1 mem_re. Without macro: cons at 0xFFFF reads 0xFFFF, 0x0000, 0x0001.
- Assert rst during W0_RD, then request 0x10 -> a single correct response for 0x10; the stale in-flight read is ignored.

Source files
------------

// File: rtl/cell_fetch.sv
// Heap-cell fetch engine: reads a tag word, then 0/1/2 payload words, and returns them with an error code.
// Optional macro CELL_FETCH_BOUNDS_CHECK_EN enables HEAP_TOP range checks (error code 3).
module cell_fetch #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int READ_LATENCY = 2,
  parameter logic [DATA_WIDTH-1:0] TAG_NUMBER = 16'h0001,
  parameter logic [DATA_WIDTH-1:0] TAG_CONS = 16'h0002,
  parameter logic [ADDR_WIDTH-1:0] HEAP_TOP = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_error,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_tag,
  output logic [DATA_WIDTH-1:0] rsp_word0,
  output logic [DATA_WIDTH-1:0] rsp_word1,
  output logic [1:0]            rsp_err
);

  typedef enum logic [2:0] {S_IDLE, S_TAG_RD, S_W0_RD, S_W1_RD, S_RESP} state_t;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);
  localparam logic [1:0] ERR_OK = 2'd0, ERR_TAG = 2'd1, ERR_MEM = 2'd2, ERR_BND = 2'd3;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  is_cons_q, is_cons_d;
  logic                  mem_re_q, mem_re_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] rsp_tag_q, rsp_tag_d;
  logic [DATA_WIDTH-1:0] rsp_word0_q, rsp_word0_d;
  logic [DATA_WIDTH-1:0] rsp_word1_q, rsp_word1_d;
  logic [1:0]            rsp_err_q, rsp_err_d;

  logic tag_is_num, tag_is_cons, idle_oob, span_bad;

  assign tag_is_num  = (mem_rdata == TAG_NUMBER);
  assign tag_is_cons = (mem_rdata == TAG_CONS);

`ifdef CELL_FETCH_BOUNDS_CHECK_EN
  // One extra bit so a cell straddling the top of the address space is caught, not wrapped.
  logic [ADDR_WIDTH:0] span_end;
  assign span_end = {1'b0, base_q} + (tag_is_cons ? (ADDR_WIDTH+1)'(2) : (ADDR_WIDTH+1)'(1));
  assign span_bad = span_end > {1'b0, HEAP_TOP};
  assign idle_oob = req_addr > HEAP_TOP;
`else
  logic unused_heap_top;
  assign unused_heap_top = ^HEAP_TOP;
  assign span_bad = 1'b0;
  assign idle_oob = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    is_cons_d   = is_cons_q;
    mem_re_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_word0_d = rsp_word0_q;
    rsp_word1_d = rsp_word1_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          base_d      = req_addr;
          is_cons_d   = 1'b0;
          rsp_tag_d   = '0;
          rsp_word0_d = '0;
          rsp_word1_d = '0;
          rsp_err_d   = ERR_OK;
          if (idle_oob) begin
            state_d   = S_RESP;
            rsp_err_d = ERR_BND;
          end else begin
            state_d    = S_TAG_RD;
            mem_re_d   = 1'b1;
            mem_addr_d = req_addr;
            cnt_d      = LAT;
          end
        end
      end
      S_TAG_RD, S_W0_RD, S_W1_RD: begin
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        // A fault anywhere in the read window beats whatever the data would have decoded to.
        if (mem_error) begin
          state_d   = S_RESP;
          rsp_err_d = ERR_MEM;
        end else if (cnt_q == 3'd0) begin
          if (state_q == S_TAG_RD) begin
            rsp_tag_d = mem_rdata;
            if (!(tag_is_num || tag_is_cons)) begin
              state_d   = S_RESP;
              rsp_err_d = ERR_TAG;
            end else if (span_bad) begin
              state_d   = S_RESP;
              rsp_err_d = ERR_BND;
            end else begin
              is_cons_d  = tag_is_cons;
              state_d    = S_W0_RD;
              mem_re_d   = 1'b1;
              mem_addr_d = base_q + ADDR_WIDTH'(1);
              cnt_d      = LAT;
            end
          end else if (state_q == S_W0_RD) begin
            rsp_word0_d = mem_rdata;
            if (is_cons_q) begin
              state_d    = S_W1_RD;
              mem_re_d   = 1'b1;
              mem_addr_d = base_q + ADDR_WIDTH'(2);
              cnt_d      = LAT;
            end else begin
              state_d = S_RESP;
            end
          end else begin
            rsp_word1_d = mem_rdata;
            state_d     = S_RESP;
          end
        end
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      cnt_q       <= '0;
      is_cons_q   <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_word0_q <= '0;
      rsp_word1_q <= '0;
      rsp_err_q   <= ERR_OK;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      is_cons_q   <= is_cons_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_word0_q <= rsp_word0_d;
      rsp_word1_q <= rsp_word1_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign rsp_valid = (state_q == S_RESP);
  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_word0 = rsp_word0_q;
  assign rsp_word1 = rsp_word1_q;
  assign rsp_err   = rsp_err_q;

endmodule
